// File: rtl/up_state_pkg.sv
// Shared types and widths for the uP run-state controller.
package up_state_pkg;

    localparam int BOOT_ADDR_W = 15;
    localparam int WORD_W      = 16;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PAUSING = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    // The Core holds pause only while the request stays high, so both
    // pause states drive it.
    function automatic logic pause_requested(input state_t s);
        return (s == PAUSING) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> two-flop synchronizer -> debounced level -> one-cycle press pulse
// on each debounced 0->1 edge.
module btn_debounce #(
    parameter int DBNC_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_level,
    output logic o_pressPulse
);

    localparam int                CNT_W    = $clog2(DBNC_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only advances while the synchronized input disagrees with the
    // debounced level; any cycle of agreement (a bounce) restarts it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_q & ~prev_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q  <= {sync_q[0], i_raw};
            level_q <= level_d;
            prev_q  <= level_q;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level      = level_q;
    assign o_pressPulse = pulse_q;

endmodule

// File: rtl/up_state.sv
// uP run-state controller: streams the boot image into memory, then sequences
// RUN/PAUSE from the debounced button and the Core's HLT report.
module up_state
    import up_state_pkg::*;
#(
    parameter int BOOT_WORDS  = 32768,
    parameter int DBNC_CYCLES = 50000
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [WORD_W-1:0] i_bootData,
    input  logic              i_bootValid,
    output logic              o_bootReady,
    output logic [WORD_W-1:0] o_bootAddr,
    output logic [WORD_W-1:0] o_bootDataOut,
    output logic              o_bootWr,
    input  logic              i_pauseBtn,
    output logic              o_smIsBooted,
    output logic              o_smStartPause,
    input  logic              i_smNowPaused,
    input  logic              i_reportHLT,
    output logic [1:0]        o_state
);

    localparam int               CNT_W     = BOOT_ADDR_W + 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              wr_q, wr_d;
    logic              booted_q, booted_d;
    logic              pause_q, pause_d;
    logic              boot_accept;
    logic              press;
    logic              btn_level_unused;

    btn_debounce #(
        .DBNC_CYCLES (DBNC_CYCLES)
    ) u_btn (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_raw        (i_pauseBtn),
        .o_level      (btn_level_unused),
        .o_pressPulse (press)
    );

    // Ready is decoded, not registered; qualifying it with reset keeps it low
    // while reset is held even though the decoded state says BOOT.
    assign o_bootReady = i_rstn && (state_q == BOOT) && (cnt_q < BOOT_LAST);
    assign boot_accept = i_bootValid && o_bootReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;

        if (boot_accept) begin
            addr_d = {1'b0, cnt_q[BOOT_ADDR_W-1:0]};
            data_d = i_bootData;
            wr_d   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end

        case (state_q)
            BOOT:    if (cnt_q == BOOT_LAST)        state_d = RUN;
            RUN:     if (press || i_reportHLT)      state_d = PAUSING;
            PAUSING: if (i_smNowPaused)             state_d = PAUSED;
            PAUSED:  if (press)                     state_d = RUN;
            default:                                state_d = BOOT;
        endcase

        booted_d = (state_d != BOOT);
        pause_d  = pause_requested(state_d);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= BOOT;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            booted_q <= 1'b0;
            pause_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            booted_q <= booted_d;
            pause_q  <= pause_d;
        end
    end

    assign o_bootAddr     = addr_q;
    assign o_bootDataOut  = data_q;
    assign o_bootWr       = wr_q;
    assign o_smIsBooted   = booted_q;
    assign o_smStartPause = pause_q;
    assign o_state        = state_q;

endmodule
